// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer in front of D_memory.
//
// Takes one request per cycle from EX/MEM, drives D_memory's address, data_in
// and active-low write_en, and hides the memory's one-cycle synchronous read
// latency. Load results go to writeback over a valid/ready handshake. If
// writeback stalls, the result is parked in a skid register (hold_data).
//
// Ports:
//   clk, rst        - system clock; synchronous active-high reset
//   req_*           - request channel (op: 00 NOP, 01 LW, 10 SW, 11 reserved/NOP)
//   mem_*           - D_memory interface (write_en active-low; data_out valid
//                     one cycle after the address edge)
//   resp_*          - load result channel to writeback
//   ld_count        - loads accepted since reset (wraps)
//   st_count        - stores accepted since reset (wraps)
//
// state | meaning
// IDLE  | no load outstanding
// RD    | load issued on the previous edge; its data is on mem_data_out now
// HOLD  | load data parked in hold_data, waiting for resp_ready
module mem_access_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [REG_W-1:0]  req_rd,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [REG_W-1:0]  resp_rd,
    output logic [CNT_W-1:0]  ld_count,
    output logic [CNT_W-1:0]  st_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [REG_W-1:0]    resp_rd_q, resp_rd_d;
    logic [CNT_W-1:0]    ld_count_q, ld_count_d;
    logic [CNT_W-1:0]    st_count_q, st_count_d;

    logic fire;
    logic fire_lw;
    logic fire_sw;

    always_comb begin
        // While a result is pending, a new request may only enter in the cycle
        // the current result is consumed, so the response slot never overflows.
        if (rst) begin
            req_ready = 1'b0;
        end else if (state_q == IDLE) begin
            req_ready = 1'b1;
        end else begin
            req_ready = resp_ready;
        end

        fire    = req_valid & req_ready;
        fire_lw = fire & (req_op == OP_LW);
        fire_sw = fire & (req_op == OP_SW);

        mem_address  = fire ? req_addr : last_addr_q;
        mem_data_in  = req_wdata;
        mem_write_en = rst | ~fire_sw;

        // Gate with rst so a load caught mid-flight never shows up as a result.
        resp_valid = ~rst & (state_q != IDLE);
        if (rst) begin
            resp_data = '0;
        end else begin
            case (state_q)
                RD:      resp_data = mem_data_out;
                HOLD:    resp_data = hold_data_q;
                default: resp_data = '0;
            endcase
        end
        resp_rd  = resp_rd_q;
        ld_count = ld_count_q;
        st_count = st_count_q;

        state_d     = state_q;
        hold_data_d = hold_data_q;
        last_addr_d = fire ? req_addr : last_addr_q;
        resp_rd_d   = fire_lw ? req_rd : resp_rd_q;
        ld_count_d  = fire_lw ? ld_count_q + CNT_W'(1) : ld_count_q;
        st_count_d  = fire_sw ? st_count_q + CNT_W'(1) : st_count_q;

        case (state_q)
            IDLE: begin
                if (fire_lw) state_d = RD;
            end
            RD: begin
                if (resp_ready) begin
                    state_d = fire_lw ? RD : IDLE;
                end else begin
                    // mem_data_out only lasts one cycle; capture it now.
                    hold_data_d = mem_data_out;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (resp_ready) state_d = fire_lw ? RD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            last_addr_q <= '0;
            resp_rd_q   <= '0;
            ld_count_q  <= '0;
            st_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            last_addr_q <= last_addr_d;
            resp_rd_q   <= resp_rd_d;
            ld_count_q  <= ld_count_d;
            st_count_q  <= st_count_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_rd;
    logic [7:0]  mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_en;
    logic [15:0] mem_data_out = 16'h0;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [3:0]  resp_rd;
    logic [15:0] ld_count;
    logic [15:0] st_count;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd),
        .ld_count(ld_count), .st_count(st_count)
    );

    // Behavioural D_memory: synchronous read, active-low write.
    logic [15:0] dmem [256];
    always @(posedge clk) begin
        mem_data_out <= dmem[mem_address];
        if (!mem_write_en) dmem[mem_address] <= mem_data_in;
    end

    // Reference model: architectural memory, outstanding-result flag, counts.
    logic [15:0] ref_mem [256];
    logic [19:0] exp_q [$];   // {data, rd}
    bit          pending;
    int          ld_ref, st_ref;
    int          checks = 0;
    int          passes = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a,
                        input logic [15:0] wd, input logic [3:0] rd,
                        input logic rr, input logic r);
        bit exp_ready;
        bit f;
        rst = r; req_valid = v; req_op = op; req_addr = a;
        req_wdata = wd; req_rd = rd; resp_ready = rr;
        @(negedge clk);
        if (r) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_write_en", mem_write_en, 1);
            pending = 0;
            exp_q.delete();
            ld_ref = 0;
            st_ref = 0;
        end else begin
            exp_ready = pending ? rr : 1'b1;
            chk("req_ready", req_ready, exp_ready);
            chk("resp_valid", resp_valid, pending);
            if (!pending) chk("idle_resp_data", resp_data, 0);
            chk("ld_count", ld_count, ld_ref[15:0]);
            chk("st_count", st_count, st_ref[15:0]);
            f = v & exp_ready;
            chk("mem_write_en", mem_write_en, !(f && op == 2'b10));
            if (pending && rr) pending = 0;
            if (f && op == 2'b01) begin
                exp_q.push_back({ref_mem[a], rd});
                pending = 1;
                ld_ref++;
            end else if (f && op == 2'b10) begin
                ref_mem[a] = wd;
                st_ref++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each presented result with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", resp_valid, 0);
            end else begin
                chk("resp_data", resp_data, exp_q[0][19:4]);
                chk("resp_rd", resp_rd, exp_q[0][3:0]);
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic setmem(input logic [7:0] a, input logic [15:0] d);
        dmem[a] = d;
        ref_mem[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) setmem(i[7:0], 16'($urandom));
        setmem(8'h05, 16'h1234);
        setmem(8'h01, 16'h00A1);
        setmem(8'h02, 16'h00A2);
        setmem(8'h03, 16'h00A3);
        setmem(8'h07, 16'h5555);
        pending = 0; ld_ref = 0; st_ref = 0;
        rst = 1; req_valid = 0; req_op = 0; req_addr = 0;
        req_wdata = 0; req_rd = 0; resp_ready = 1;
        @(posedge clk); #1;
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 1);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);
        chk("reset_ld_count", ld_count, 0);
        chk("reset_resp_rd", resp_rd, 0);

        // Single load, then idle.
        step(1, 2'b01, 8'h05, 16'h0, 4'h9, 1, 0);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);

        // Store then load of the same word.
        step(1, 2'b10, 8'h10, 16'hBEEF, 4'h0, 1, 0);
        step(1, 2'b01, 8'h10, 16'h0, 4'h3, 1, 0);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);

        // Back-to-back loads.
        step(1, 2'b01, 8'h01, 16'h0, 4'h1, 1, 0);
        step(1, 2'b01, 8'h02, 16'h0, 4'h2, 1, 0);
        step(1, 2'b01, 8'h03, 16'h0, 4'h3, 1, 0);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);

        // Writeback stall with a store waiting, then release.
        step(1, 2'b01, 8'h07, 16'h0, 4'h7, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 2'b10, 8'h07, 16'hCAFE, 4'h0, 0, 0);
        step(1, 2'b10, 8'h07, 16'hCAFE, 4'h0, 1, 0);
        step(1, 2'b01, 8'h07, 16'h0, 4'h4, 1, 0);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);

        // Reserved op and NOP.
        step(1, 2'b11, 8'h20, 16'h1111, 4'h0, 1, 0);
        step(1, 2'b00, 8'h21, 16'h2222, 4'h0, 1, 0);

        // Load then reset mid-flight.
        step(1, 2'b01, 8'h05, 16'h0, 4'h5, 0, 0);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 0, 1);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);
        step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);

        // Randomized traffic on a small address window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom_range(0, 15)),
                 16'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 60) == 0));
        end

        for (int i = 0; i < 4; i++) step(0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store sequencer sitting directly upstream of D_memory.
- Accepts one memory request per cycle from the EX/MEM pipeline register and drives D_memory's address, data_in and active-low write_en.
- Absorbs D_memory's 1-cycle synchronous read latency and presents load results to writeback over a valid/ready handshake.
- Holds load data in a skid register while writeback stalls.

Parameters:
- DATA_W, 16, data word width; equals `DSIZE.
- ADDR_W, 8, word-address width; equals `MEM_SPACE.
- REG_W, 4, destination-register tag width.
- CNT_W, 16, width of the load and store event counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_op  in  2  00 NOP, 01 LW, 10 SW, 11 reserved (executed as NOP).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_rd  in  REG_W  load destination tag.
- mem_address  out  ADDR_W  to D_memory address.
- mem_data_in  out  DATA_W  to D_memory data_in.
- mem_write_en  out  1  to D_memory write_en; active-low.
- mem_data_out  in  DATA_W  from D_memory data_out; valid 1 cycle after the address edge.
- resp_valid  out  1  load result valid.
- resp_ready  in  1  writeback accepts the result.
- resp_data  out  DATA_W  load data.
- resp_rd  out  REG_W  destination tag of the load.
- ld_count  out  CNT_W  loads accepted since reset.
- st_count  out  CNT_W  stores accepted since reset.

Behaviour:
- Accept: fire = req_valid & req_ready.
- FSM states:
  - IDLE: no load outstanding.
  - RD: a load was issued on the previous edge; its data is on mem_data_out now.
  - HOLD: load data is parked in hold_data.
- req_ready:
  - IDLE: 1.
  - RD and HOLD: equals resp_ready. This is a combinational path and is permitted.
  - Forced to 0 while rst is high.
- Memory drive (combinational):
  - mem_address = req_addr when fire, else last_addr. last_addr is registered on every fire.
  - mem_data_in = req_wdata.
  - mem_write_en = ~(fire & op==SW).
  - mem_write_en is forced to 1 while rst is high.
- Stores and NOPs:
  - Complete on the accept cycle; no response is generated.
  - A store fires in any state in which req_ready=1. This includes the cycle a load response is consumed; that load's data was already read, so there is no ordering hazard.
- Load latency: load fired in cycle N gives resp_valid=1 in cycle N+1 with resp_data = mem_data_out.
- Throughput: 1 load/cycle while resp_ready stays high.
- Transitions:
  - IDLE: fire LW -> RD; else stay IDLE.
  - RD, resp_ready=1: result consumed. Fire LW -> RD; else -> IDLE.
  - RD, resp_ready=0: hold_data <= mem_data_out, -> HOLD.
  - HOLD: resp_data = hold_data. On resp_ready=1: fire LW -> RD; else -> IDLE. On resp_ready=0: stay HOLD.
- resp_rd is a register loaded on each LW fire; it is stable through RD and HOLD.
- Outputs:
  - resp_valid = (state != IDLE).
  - resp_data mux: mem_data_out in RD, hold_data in HOLD, 0 in IDLE.
- Counters: ld_count increments on fire & LW; st_count increments on fire & SW. Both wrap modulo 2^CNT_W.
- Reset values: state IDLE, resp_valid 0, resp_data 0, resp_rd 0, hold_data 0, last_addr 0, ld_count 0, st_count 0, mem_write_en 1.
- Reset mid-operation: an outstanding or held load is discarded; no response is ever produced for it.
- Reserved op 11: accepted, counted in neither counter, no memory write.

Test Plan:
- Reset then LW addr 0x05, with memory[5]=0x1234 and resp_ready=1 -> cycle N+1: resp_valid=1, resp_data=0x1234, resp_rd=tag; cycle N+2: resp_valid=0; ld_count=1.
- SW addr 0x10 data 0xBEEF, then LW addr 0x10 next cycle -> mem_write_en low for exactly 1 cycle; load returns 0xBEEF; st_count=1, ld_count=1.
- Back-to-back LW 0x01, 0x02, 0x03 (data 0xA1, 0xA2, 0xA3) with resp_ready=1 -> resp_valid high 3 consecutive cycles, data 0xA1, 0xA2, 0xA3 in order; req_ready never drops.
- LW 0x07 (data 0x5555), resp_ready=0 for 3 cycles while req_valid=1 with SW pending -> state HOLD; resp_data stays 0x5555; req_ready=0; mem_write_en stays 1. Raise resp_ready -> response consumed and SW fires that cycle.
- LW fired, then rst asserted the next cycle -> resp_valid=0, mem_write_en=1 during reset; no response appears after reset release; counters read 0.
- op=11 and NOP requests -> accepted (req_ready=1), mem_write_en stays 1, no resp_valid, counters unchanged.
